axi_gpio_in: RTL and testbench

AXI_GPIO_IN -- requirements
Module: axi_gpio_in

---
 rtl/uninasoc_pkg.sv | 33 +++
 rtl/gpio_sync.sv | 23 ++
 rtl/axi_gpio_in.sv | 176 +++++++++++++++++
 tb/tb_axi_gpio_in.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uninasoc_pkg.sv
// rtl/uninasoc_pkg.sv - SoC-wide constants, register offsets and AXI types shared by peripherals
package uninasoc_pkg;

  localparam int NUM_GPIO_IN    = 1;
  localparam int NUM_GPIO_OUT   = 0;
  // Main memory and UART are always present; each GPIO block adds one slave port.
  localparam int NUM_AXI_SLAVES = 2 + NUM_GPIO_IN + NUM_GPIO_OUT;

  typedef enum logic [1:0] {
    AXI_RESP_OKAY   = 2'b00,
    AXI_RESP_EXOKAY = 2'b01,
    AXI_RESP_SLVERR = 2'b10,
    AXI_RESP_DECERR = 2'b11
  } axi_resp_t;

  // Word index within the GPIO-in block (address bits [3:2]).
  localparam logic [1:0] GPIO_IN_DATA       = 2'd0;
  localparam logic [1:0] GPIO_IN_IRQ_EN     = 2'd1;
  localparam logic [1:0] GPIO_IN_IRQ_STATUS = 2'd2;
  localparam logic [1:0] GPIO_IN_EDGE_SEL   = 2'd3;

  typedef enum logic { W_IDLE, W_RESP } wr_state_t;
  typedef enum logic { R_IDLE, R_RESP } rd_state_t;

  function automatic logic [31:0] strb_mask(input logic [3:0] strb);
    logic [31:0] mask;
    for (int i = 0; i < 4; i++) begin
      mask[8*i +: 8] = {8{strb[i]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/gpio_sync.sv
// rtl/gpio_sync.sv - parameterized-width two-flop synchronizer for asynchronous pins
module gpio_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] pins,
  output logic [WIDTH-1:0] sync
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      meta <= '0;
      sync <= '0;
    end else begin
      meta <= pins;
      sync <= meta;
    end
  end

endmodule

// File: rtl/axi_gpio_in.sv
// rtl/axi_gpio_in.sv - AXI4-Lite GPIO input block with per-pin edge interrupts
module axi_gpio_in
  import uninasoc_pkg::*;
#(
  parameter int NUM_GPIO   = 8,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clock_i,
  input  logic                  reset_ni,
  input  logic [NUM_GPIO-1:0]   gpio_in_i,
  output logic                  irq_o,
  input  logic [ADDR_WIDTH-1:0] s_axilite_awaddr,
  input  logic                  s_axilite_awvalid,
  output logic                  s_axilite_awready,
  input  logic [31:0]           s_axilite_wdata,
  input  logic [3:0]            s_axilite_wstrb,
  input  logic                  s_axilite_wvalid,
  output logic                  s_axilite_wready,
  output logic [1:0]            s_axilite_bresp,
  output logic                  s_axilite_bvalid,
  input  logic                  s_axilite_bready,
  input  logic [ADDR_WIDTH-1:0] s_axilite_araddr,
  input  logic                  s_axilite_arvalid,
  output logic                  s_axilite_arready,
  output logic [31:0]           s_axilite_rdata,
  output logic [1:0]            s_axilite_rresp,
  output logic                  s_axilite_rvalid,
  input  logic                  s_axilite_rready
);

  logic [NUM_GPIO-1:0] pin_sync, pin_prev, irq_en, irq_status, edge_sel;
  logic [NUM_GPIO-1:0] edge_hit, lane_mask, wr_bits, w1c, w_data_q;
  logic [31:0]         byte_mask, rd_val;
  logic [1:0]          aw_idx_q, wr_idx;
  logic [3:0]          w_strb_q, wr_strb;
  logic                ports_on, aw_held, w_held, aw_fire, w_fire, ar_fire, wr_commit;
  wr_state_t           wr_state, wr_next;
  rd_state_t           rd_state, rd_next;
  logic                unused;

  assign unused = ^{s_axilite_awaddr, s_axilite_araddr, s_axilite_wdata, byte_mask};

  gpio_sync #(.WIDTH(NUM_GPIO)) u_sync (
    .clk    (clock_i),
    .resetn (reset_ni),
    .pins   (gpio_in_i),
    .sync   (pin_sync)
  );

  // EDGE_SEL bit 0 picks rising, 1 picks falling.
  assign edge_hit = (edge_sel & ~pin_sync & pin_prev) | (~edge_sel & pin_sync & ~pin_prev);

  assign aw_fire   = s_axilite_awvalid & s_axilite_awready;
  assign w_fire    = s_axilite_wvalid & s_axilite_wready;
  assign ar_fire   = s_axilite_arvalid & s_axilite_arready;
  assign wr_idx    = aw_held ? aw_idx_q : s_axilite_awaddr[3:2];
  assign wr_bits   = w_held ? w_data_q : s_axilite_wdata[NUM_GPIO-1:0];
  assign wr_strb   = w_held ? w_strb_q : s_axilite_wstrb;
  assign byte_mask = strb_mask(wr_strb);
  assign lane_mask = byte_mask[NUM_GPIO-1:0];
  assign wr_commit = (wr_state == W_IDLE) && (aw_held || aw_fire) && (w_held || w_fire);
  assign w1c       = (wr_commit && wr_idx == GPIO_IN_IRQ_STATUS) ? (wr_bits & lane_mask) : '0;

  always_comb begin
    wr_next           = wr_state;
    s_axilite_awready = 1'b0;
    s_axilite_wready  = 1'b0;
    s_axilite_bvalid  = 1'b0;
    unique case (wr_state)
      W_IDLE: begin
        // A channel already held is not re-accepted until the pair completes.
        s_axilite_awready = ports_on & ~aw_held;
        s_axilite_wready  = ports_on & ~w_held;
        if (wr_commit) wr_next = W_RESP;
      end
      W_RESP: begin
        s_axilite_bvalid = 1'b1;
        if (s_axilite_bready) wr_next = W_IDLE;
      end
      default: wr_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (!reset_ni) begin
      wr_state        <= W_IDLE;
      aw_held         <= 1'b0;
      w_held          <= 1'b0;
      aw_idx_q        <= '0;
      w_data_q        <= '0;
      w_strb_q        <= '0;
      s_axilite_bresp <= AXI_RESP_OKAY;
    end else begin
      wr_state <= wr_next;
      if (wr_commit) begin
        aw_held         <= 1'b0;
        w_held          <= 1'b0;
        s_axilite_bresp <= (wr_idx == GPIO_IN_DATA) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
      end else begin
        if (aw_fire) begin
          aw_held  <= 1'b1;
          aw_idx_q <= s_axilite_awaddr[3:2];
        end
        if (w_fire) begin
          w_held   <= 1'b1;
          w_data_q <= s_axilite_wdata[NUM_GPIO-1:0];
          w_strb_q <= s_axilite_wstrb;
        end
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (!reset_ni) begin
      ports_on   <= 1'b0;
      pin_prev   <= '0;
      irq_en     <= '0;
      irq_status <= '0;
      edge_sel   <= '0;
      irq_o      <= 1'b0;
    end else begin
      ports_on   <= 1'b1;
      pin_prev   <= pin_sync;
      // A fresh edge outranks a simultaneous clear of the same bit.
      irq_status <= (irq_status & ~w1c) | edge_hit;
      irq_o      <= |(irq_status & irq_en);
      if (wr_commit && wr_idx == GPIO_IN_IRQ_EN)
        irq_en <= (irq_en & ~lane_mask) | (wr_bits & lane_mask);
      if (wr_commit && wr_idx == GPIO_IN_EDGE_SEL)
        edge_sel <= (edge_sel & ~lane_mask) | (wr_bits & lane_mask);
    end
  end

  always_comb begin
    rd_val = '0;
    case (s_axilite_araddr[3:2])
      GPIO_IN_DATA:       rd_val = 32'(pin_sync);
      GPIO_IN_IRQ_EN:     rd_val = 32'(irq_en);
      GPIO_IN_IRQ_STATUS: rd_val = 32'(irq_status);
      GPIO_IN_EDGE_SEL:   rd_val = 32'(edge_sel);
      default:            rd_val = '0;
    endcase
  end

  always_comb begin
    rd_next           = rd_state;
    s_axilite_arready = 1'b0;
    s_axilite_rvalid  = 1'b0;
    unique case (rd_state)
      R_IDLE: begin
        s_axilite_arready = ports_on;
        if (ar_fire) rd_next = R_RESP;
      end
      R_RESP: begin
        s_axilite_rvalid = 1'b1;
        if (s_axilite_rready) rd_next = R_IDLE;
      end
      default: rd_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (!reset_ni) begin
      rd_state        <= R_IDLE;
      s_axilite_rdata <= '0;
      s_axilite_rresp <= AXI_RESP_OKAY;
    end else begin
      rd_state <= rd_next;
      if (ar_fire) begin
        s_axilite_rdata <= rd_val;
        s_axilite_rresp <= AXI_RESP_OKAY;
      end
    end
  end

endmodule

// File: tb/tb_axi_gpio_in.sv
// tb/tb_axi_gpio_in.sv - directed-vector bench for axi_gpio_in
module tb_axi_gpio_in;

  logic        clk = 1'b0;
  logic        resetn;
  logic [7:0]  gpio;
  logic        irq;
  logic [31:0] awaddr, wdata, araddr;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready;
  logic [1:0]  bresp, rresp;
  logic        bvalid, bready, arvalid, arready, rvalid, rready;
  logic [31:0] rdata;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  axi_gpio_in #(.NUM_GPIO(8), .ADDR_WIDTH(32)) dut (
    .clock_i           (clk),
    .reset_ni          (resetn),
    .gpio_in_i         (gpio),
    .irq_o             (irq),
    .s_axilite_awaddr  (awaddr),
    .s_axilite_awvalid (awvalid),
    .s_axilite_awready (awready),
    .s_axilite_wdata   (wdata),
    .s_axilite_wstrb   (wstrb),
    .s_axilite_wvalid  (wvalid),
    .s_axilite_wready  (wready),
    .s_axilite_bresp   (bresp),
    .s_axilite_bvalid  (bvalid),
    .s_axilite_bready  (bready),
    .s_axilite_araddr  (araddr),
    .s_axilite_arvalid (arvalid),
    .s_axilite_arready (arready),
    .s_axilite_rdata   (rdata),
    .s_axilite_rresp   (rresp),
    .s_axilite_rvalid  (rvalid),
    .s_axilite_rready  (rready)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
    logic aw_go, w_go, got;
    awaddr = addr; wdata = data; wstrb = strb;
    awvalid = 1'b1; wvalid = 1'b1;
    for (int n = 0; n < 20 && (awvalid || wvalid); n++) begin
      aw_go = awvalid && awready;
      w_go  = wvalid && wready;
      step();
      if (aw_go) awvalid = 1'b0;
      if (w_go)  wvalid  = 1'b0;
    end
    chk("aw_w_handshake", {31'd0, !(awvalid || wvalid)}, 32'd1);
    awvalid = 1'b0; wvalid = 1'b0;
    bready = 1'b1; got = 1'b0; resp = 2'b11;
    for (int n = 0; n < 20 && !got; n++) begin
      if (bvalid) begin
        got = 1'b1;
        resp = bresp;
      end
      step();
    end
    bready = 1'b0;
    chk("b_handshake", {31'd0, got}, 32'd1);
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data, output logic lat_ok);
    logic hs, got;
    araddr = addr; arvalid = 1'b1; hs = 1'b0;
    for (int n = 0; n < 20 && !hs; n++) begin
      if (arready) hs = 1'b1;
      step();
    end
    arvalid = 1'b0;
    chk("ar_handshake", {31'd0, hs}, 32'd1);
    lat_ok = rvalid;
    rready = 1'b1; got = 1'b0; data = 32'hDEAD_BEEF;
    for (int n = 0; n < 20 && !got; n++) begin
      if (rvalid) begin
        got = 1'b1;
        data = rdata;
        chk("rresp_okay", {30'd0, rresp}, 32'd0);
      end
      step();
    end
    rready = 1'b0;
    chk("r_handshake", {31'd0, got}, 32'd1);
  endtask

  task automatic wr_chk(input string tag, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, input logic [1:0] exp_resp);
    logic [1:0] resp;
    axi_write(addr, data, strb, resp);
    chk(tag, {30'd0, resp}, {30'd0, exp_resp});
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    logic lat;
    axi_read(addr, d, lat);
    chk(tag, d, exp);
  endtask

  task automatic split_write(input logic [31:0] addr, input logic [31:0] data, input logic aw_first);
    logic go;
    int bcnt;
    if (aw_first) begin awaddr = addr; awvalid = 1'b1; end
    else begin wdata = data; wstrb = 4'hF; wvalid = 1'b1; end
    go = 1'b0;
    for (int n = 0; n < 20 && !go; n++) begin
      go = aw_first ? awready : wready;
      step();
    end
    awvalid = 1'b0; wvalid = 1'b0;
    repeat (3) step();
    chk("split_first_not_answered", {31'd0, bvalid}, 32'd0);
    if (aw_first) begin wdata = data; wstrb = 4'hF; wvalid = 1'b1; end
    else begin awaddr = addr; awvalid = 1'b1; end
    go = 1'b0;
    for (int n = 0; n < 20 && !go; n++) begin
      go = aw_first ? wready : awready;
      step();
    end
    awvalid = 1'b0; wvalid = 1'b0;
    bcnt = 0;
    repeat (5) begin
      bcnt += int'(bvalid);
      step();
    end
    chk("split_bvalid_held", bcnt, 5);
    chk("split_bresp", {30'd0, bresp}, 32'd0);
    bready = 1'b1;
    step();
    bready = 1'b0;
    bcnt = 0;
    repeat (4) begin
      bcnt += int'(bvalid);
      step();
    end
    chk("split_single_b", bcnt, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int bcnt;
    resetn = 1'b0; gpio = 8'h00;
    awaddr = '0; wdata = '0; wstrb = '0; awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arvalid = 1'b0; rready = 1'b0;
    repeat (3) step();
    chk("rst_ctrl_outputs", {24'd0, awready, wready, bvalid, arready, rvalid, irq, 2'b00}, 32'd0);
    chk("rst_resp_codes", {28'd0, bresp, rresp}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    resetn = 1'b1;
    repeat (2) step();

    begin
      logic [31:0] d;
      logic lat;
      gpio = 8'h01;
      repeat (4) step();
      axi_read(32'h0, d, lat);
      chk("read_latency_one", {31'd0, lat}, 32'd1);
      chk("data_pin0", d, 32'h1);
    end
    rd_chk("status_without_enable", 32'h8, 32'h1);
    wr_chk("w1c_resp", 32'h8, 32'h1, 4'hF, 2'b00);
    rd_chk("status_cleared", 32'h8, 32'h0);

    wr_chk("irq_en_resp", 32'h4, 32'h1, 4'hF, 2'b00);
    rd_chk("irq_en_readback", 32'h4, 32'h1);
    gpio[0] = 1'b0;
    repeat (5) step();
    rd_chk("fall_ignored_rising_sel", 32'h8, 32'h0);
    chk("irq_low_no_status", {31'd0, irq}, 32'd0);
    gpio[0] = 1'b1;
    repeat (5) step();
    chk("irq_on_rise", {31'd0, irq}, 32'd1);
    rd_chk("status_on_rise", 32'h8, 32'h1);
    awaddr = 32'h8; wdata = 32'h1; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    step();
    awvalid = 1'b0; wvalid = 1'b0;
    chk("irq_still_high_at_w1c", {31'd0, irq}, 32'd1);
    chk("bvalid_after_w1c", {31'd0, bvalid}, 32'd1);
    step();
    chk("irq_low_cycle_after_w1c", {31'd0, irq}, 32'd0);
    bready = 1'b1;
    step();
    bready = 1'b0;

    wr_chk("edge_sel_resp", 32'hC, 32'h4, 4'hF, 2'b00);
    gpio[2] = 1'b1;
    repeat (5) step();
    rd_chk("pin2_rise_ignored", 32'h8, 32'h0);
    gpio[2] = 1'b0;
    repeat (5) step();
    rd_chk("pin2_fall_sets", 32'h8, 32'h4);
    chk("irq_masked_bit2", {31'd0, irq}, 32'd0);
    wr_chk("w1c_bit2_resp", 32'h8, 32'h4, 4'hF, 2'b00);
    rd_chk("status_bit2_cleared", 32'h8, 32'h0);

    split_write(32'h4, 32'h3, 1'b1);
    rd_chk("split_aw_first_value", 32'h4, 32'h3);
    split_write(32'h4, 32'h5, 1'b0);
    rd_chk("split_w_first_value", 32'h4, 32'h5);

    wr_chk("data_write_slverr", 32'h0, 32'hFF, 4'hF, 2'b10);
    rd_chk("data_unchanged", 32'h0, 32'h1);
    wr_chk("zero_strb_okay", 32'h4, 32'h0, 4'h0, 2'b00);
    rd_chk("zero_strb_no_effect", 32'h4, 32'h5);
    wr_chk("alias_write_resp", 32'h1004, 32'hFFFF_FFFF, 4'hF, 2'b00);
    rd_chk("upper_bits_read_zero", 32'h4, 32'hFF);
    wr_chk("upper_lanes_resp", 32'h4, 32'h0, 4'b1110, 2'b00);
    rd_chk("upper_lanes_no_effect", 32'h7, 32'hFF);
    wr_chk("lane0_resp", 32'h4, 32'h0, 4'b0001, 2'b00);
    rd_chk("lane0_cleared", 32'h4, 32'h0);

    wr_chk("clear_all_resp", 32'h8, 32'hFF, 4'hF, 2'b00);
    rd_chk("clear_all", 32'h8, 32'h0);
    gpio[1] = 1'b1;
    repeat (5) step();
    rd_chk("pin1_rise", 32'h8, 32'h2);
    gpio[1] = 1'b0;
    repeat (5) step();
    rd_chk("pin1_fall_ignored", 32'h8, 32'h2);
    gpio[1] = 1'b1;
    step();
    step();
    awaddr = 32'h8; wdata = 32'h2; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    step();
    awvalid = 1'b0; wvalid = 1'b0;
    bready = 1'b1;
    step();
    bready = 1'b0;
    rd_chk("edge_beats_w1c", 32'h8, 32'h2);

    araddr = 32'h8; arvalid = 1'b1;
    awaddr = 32'h8; wdata = 32'h2; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    step();
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    chk("concurrent_rvalid", {31'd0, rvalid}, 32'd1);
    chk("read_sees_pre_w1c", rdata, 32'h2);
    chk("concurrent_bvalid", {31'd0, bvalid}, 32'd1);
    rready = 1'b1; bready = 1'b1;
    step();
    rready = 1'b0; bready = 1'b0;
    rd_chk("w1c_took_effect", 32'h8, 32'h0);

    awaddr = 32'h4; wdata = 32'hAA; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    step();
    awvalid = 1'b0; wvalid = 1'b0;
    chk("bvalid_before_reset", {31'd0, bvalid}, 32'd1);
    resetn = 1'b0;
    step();
    chk("reset_drops_bvalid", {31'd0, bvalid}, 32'd0);
    resetn = 1'b1;
    bcnt = 0;
    repeat (6) begin
      bcnt += int'(bvalid);
      step();
    end
    chk("no_b_after_reset", bcnt, 0);
    rd_chk("irq_en_reset", 32'h4, 32'h0);
    chk("irq_reset", {31'd0, irq}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
